// File: rtl/stack_memory_controller.sv
// Sequencer for the shared data RAM / stack block.
// Serialises LOAD/STORE/PUSH/POP requests and owns the stack pointer.
module stack_memory_controller #(
    parameter int DEPTH  = 100,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int SP_W   = 7,
    parameter int RD_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [1:0]        ReqOp,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RespValid,
    output logic              RespErr,
    output logic [DATA_W-1:0] RespData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemDataIn,
    output logic              MemWrite,
    output logic              MemUseStk,
    input  logic [DATA_W-1:0] MemDataOut,
    output logic [SP_W-1:0]   StackPointer,
    output logic              StackFull,
    output logic              StackEmpty
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t            state;
    logic [SP_W-1:0]   sp;
    logic [LAT_W-1:0]  latCnt;
    logic              reqErr;

    assign ReqReady     = (state == IDLE);
    assign StackPointer = sp;
    assign StackFull    = (sp == SP_W'(DEPTH));
    assign StackEmpty   = (sp == '0);

    always_comb begin
        reqErr = 1'b0;
        case (ReqOp)
            OP_PUSH: reqErr = StackFull;
            2'b11:   reqErr = StackEmpty;
            default: reqErr = (ReqAddr >= ADDR_W'(DEPTH));
        endcase
    end

    // Mem* lines are registered so they are glitch-free and drop to 0
    // on the same edge that leaves WRITE/READ.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            sp        <= '0;
            latCnt    <= '0;
            RespValid <= 1'b0;
            RespErr   <= 1'b0;
            RespData  <= '0;
            MemAddr   <= '0;
            MemDataIn <= '0;
            MemWrite  <= 1'b0;
            MemUseStk <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        RespErr <= reqErr;
                        if (reqErr) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                        end else begin
                            case (ReqOp)
                                OP_STORE: begin
                                    state     <= WRITE;
                                    MemWrite  <= 1'b1;
                                    MemDataIn <= ReqData;
                                    MemAddr   <= ReqAddr;
                                end
                                OP_PUSH: begin
                                    state     <= WRITE;
                                    MemWrite  <= 1'b1;
                                    MemUseStk <= 1'b1;
                                    MemDataIn <= ReqData;
                                    MemAddr   <= ADDR_W'(sp);
                                end
                                OP_LOAD: begin
                                    state   <= READ;
                                    latCnt  <= LAT_W'(RD_LAT - 1);
                                    MemAddr <= ReqAddr;
                                end
                                default: begin
                                    state     <= READ;
                                    latCnt    <= LAT_W'(RD_LAT - 1);
                                    MemUseStk <= 1'b1;
                                    MemAddr   <= ADDR_W'(sp - 1'b1);
                                end
                            endcase
                        end
                    end
                end
                WRITE: begin
                    state     <= RESP;
                    RespValid <= 1'b1;
                    if (MemUseStk) sp <= sp + 1'b1;
                    MemWrite  <= 1'b0;
                    MemUseStk <= 1'b0;
                    MemAddr   <= '0;
                    MemDataIn <= '0;
                end
                READ: begin
                    if (latCnt == '0) begin
                        state     <= RESP;
                        RespValid <= 1'b1;
                        RespData  <= MemDataOut;
                        if (MemUseStk) sp <= sp - 1'b1;
                        MemUseStk <= 1'b0;
                        MemAddr   <= '0;
                        MemDataIn <= '0;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    RespValid <= 1'b0;
                    RespErr   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_memory_controller.sv
// Randomised bench for stack_memory_controller with a queue/array
// reference model and a behavioural memory block.
module tb_stack_memory_controller;

    localparam int DEPTH  = 100;
    localparam int RD_LAT = 1;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic [1:0]  ReqOp = 2'b00;
    logic [31:0] ReqAddr = '0;
    logic [31:0] ReqData = '0;
    logic        RespValid;
    logic        RespErr;
    logic [31:0] RespData;
    logic [31:0] MemAddr;
    logic [31:0] MemDataIn;
    logic        MemWrite;
    logic        MemUseStk;
    logic [31:0] MemDataOut;
    logic [6:0]  StackPointer;
    logic        StackFull;
    logic        StackEmpty;

    stack_memory_controller dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RespValid(RespValid), .RespErr(RespErr), .RespData(RespData),
        .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemWrite(MemWrite),
        .MemUseStk(MemUseStk), .MemDataOut(MemDataOut),
        .StackPointer(StackPointer), .StackFull(StackFull),
        .StackEmpty(StackEmpty)
    );

    always #5 Clock = ~Clock;

    // Memory block: no reset, synchronous write, combinational read.
    logic [31:0] memRam [0:DEPTH-1];
    logic [31:0] memStk [0:DEPTH-1];
    initial for (int i = 0; i < DEPTH; i++) begin
        memRam[i] = '0;
        memStk[i] = '0;
    end
    always @(posedge Clock)
        if (MemWrite && MemAddr < DEPTH) begin
            if (MemUseStk) memStk[MemAddr] <= MemDataIn;
            else           memRam[MemAddr] <= MemDataIn;
        end
    assign MemDataOut = (MemAddr >= DEPTH) ? 32'h0 :
                        MemUseStk ? memStk[MemAddr] : memRam[MemAddr];

    // Reference model
    logic [31:0] refRam [int];
    logic [31:0] refStk [$];
    logic [31:0] lastData = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic resetDut();
        ReqValid = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        refStk.delete();
        lastData = '0;
    endtask

    task automatic doOp(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data);
        int sp = refStk.size();
        logic err;
        logic [31:0] expAddr, expData;
        int lat = 1;
        int writes = 0;
        case (op)
            2'b10:   err = (sp == DEPTH);
            2'b11:   err = (sp == 0);
            default: err = (addr >= DEPTH);
        endcase
        expAddr = (op == 2'b10) ? sp : (op == 2'b11) ? sp - 1 : addr;
        expData = lastData;
        if (!err && op == 2'b00) expData = refRam.exists(addr) ? refRam[addr] : '0;
        if (!err && op == 2'b11) expData = refStk[$];

        @(negedge Clock);
        chk("ready_idle", {31'b0, ReqReady}, 1);
        ReqValid = 1'b1; ReqOp = op; ReqAddr = addr; ReqData = data;
        @(negedge Clock);
        ReqValid = 1'b0;
        ReqOp = 2'($urandom); ReqAddr = $urandom; ReqData = $urandom;
        if (err) begin
            chk("err_maddr", MemAddr, 0);
        end else begin
            chk("maddr", MemAddr, expAddr);
            chk("mustk", {31'b0, MemUseStk}, {31'b0, op[1]});
            if (op == 2'b01 || op == 2'b10) chk("mdin", MemDataIn, data);
        end
        while (!RespValid && lat < 10) begin
            if (MemWrite) writes++;
            @(negedge Clock);
            lat++;
        end
        chk("latency", lat, err ? 1 : (op == 2'b01 || op == 2'b10) ? 2 : RD_LAT + 1);
        chk("writes", writes, (!err && (op == 2'b01 || op == 2'b10)) ? 1 : 0);
        chk("resp_err", {31'b0, RespErr}, {31'b0, err});

        if (!err) begin
            case (op)
                2'b01:   refRam[addr] = data;
                2'b10:   refStk.push_back(data);
                2'b11:   void'(refStk.pop_back());
                default: ;
            endcase
        end
        lastData = expData;
        chk("resp_data", RespData, lastData);
        chk("sp", {25'b0, StackPointer}, refStk.size());
        chk("full", {31'b0, StackFull}, {31'b0, refStk.size() == DEPTH});
        chk("empty", {31'b0, StackEmpty}, {31'b0, refStk.size() == 0});
        chk("ready_resp", {31'b0, ReqReady}, 0);
        chk("mwrite_resp", {31'b0, MemWrite}, 0);
        chk("maddr_resp", MemAddr, 0);
        @(negedge Clock);
        chk("resp_pulse", {31'b0, RespValid}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetDut();
        @(negedge Clock);
        chk("rst_sp", {25'b0, StackPointer}, 0);
        chk("rst_empty", {31'b0, StackEmpty}, 1);
        chk("rst_ready", {31'b0, ReqReady}, 1);
        chk("rst_rvalid", {31'b0, RespValid}, 0);
        chk("rst_mwrite", {31'b0, MemWrite}, 0);
        chk("rst_rdata", RespData, 0);

        doOp(2'b01, 5, 32'hDEADBEEF);
        doOp(2'b00, 5, 32'h0);
        chk("load_val", RespData, 32'hDEADBEEF);

        doOp(2'b10, 0, 32'h11);
        doOp(2'b10, 0, 32'h22);
        doOp(2'b11, 0, 0);
        chk("pop_first", RespData, 32'h22);
        doOp(2'b11, 0, 0);
        chk("pop_second", RespData, 32'h11);

        doOp(2'b11, 0, 0);
        doOp(2'b00, 100, 0);
        doOp(2'b01, 32'hFFFF_FFFF, 32'h1234);

        for (int i = 0; i < DEPTH; i++) doOp(2'b10, 0, $urandom);
        chk("fill_full", {31'b0, StackFull}, 1);
        doOp(2'b10, 0, 32'hABCD);
        chk("overflow_sp", {25'b0, StackPointer}, DEPTH);
        for (int i = 0; i < 5; i++) doOp(2'b11, 0, 0);

        resetDut();
        for (int i = 0; i < 3; i++) doOp(2'b10, 0, $urandom);
        @(negedge Clock);
        ReqValid = 1'b1; ReqOp = 2'b11;
        @(negedge Clock);
        ReqValid = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        refStk.delete();
        lastData = '0;
        chk("abort_rvalid", {31'b0, RespValid}, 0);
        chk("abort_sp", {25'b0, StackPointer}, 0);
        chk("abort_ready", {31'b0, ReqReady}, 1);
        chk("abort_rdata", RespData, 0);
        @(negedge Clock);
        chk("abort_rvalid2", {31'b0, RespValid}, 0);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] op = 2'($urandom);
            doOp(op, $urandom_range(0, 104), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
